// File: rtl/step_dir_pkg.sv
// Shared definitions for the step/direction AXI4-Lite peripheral: register map,
// bit positions, response codes and the pulse generator state type.
package step_dir_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_STEPS  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_DIR  = 1;
   localparam int unsigned CTRL_IE   = 2;
   localparam int unsigned STAT_BUSY = 0;
   localparam int unsigned STAT_DONE = 1;

   typedef logic [1:0] resp_t;
   localparam resp_t OKAY   = 2'b00;
   localparam resp_t SLVERR = 2'b10;

   typedef enum logic [1:0] {StIdle, StPulse, StGap} state_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/step_dir_gen.sv
// Step pulse generator: IDLE/PULSE/GAP FSM with period counter and remaining-step count.
// Emits step pulses PULSE_W clocks wide, one per effective period, until the count runs out.
module step_dir_gen
   import step_dir_pkg::*;
#(
   parameter int unsigned PULSE_W = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        dir_i,
   input  logic [31:0] period_i,
   input  logic        load_i,
   input  logic [31:0] count_i,
   output logic        step_o,
   output logic        dir_o,
   output logic        busy_o,
   output logic [31:0] remaining_o,
   output logic        done_set_o
);

   localparam logic [31:0] MinPeriod = 32'(PULSE_W + 1);
   localparam logic [31:0] PulseLast = 32'(PULSE_W - 1);

   state_t      state_q;
   logic [31:0] cnt_q, per_q, rem_q;
   logic        step_q, dir_q;
   logic [31:0] eff_period;
   logic        period_end;

   // The gap must be at least one clock, so short periods stretch to PULSE_W+1.
   assign eff_period = (period_i < MinPeriod) ? MinPeriod : period_i;
   assign period_end = (state_q == StGap) && (cnt_q == per_q - 32'd1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         per_q   <= '0;
         rem_q   <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (load_i) rem_q <= count_i;
               if (en_i && rem_q != 32'd0) begin
                  state_q <= StPulse;
                  step_q  <= 1'b1;
                  dir_q   <= dir_i;
                  cnt_q   <= '0;
                  per_q   <= eff_period;
               end
            end
            StPulse: begin
               cnt_q <= cnt_q + 32'd1;
               if (cnt_q == PulseLast) begin
                  state_q <= StGap;
                  step_q  <= 1'b0;
               end
            end
            StGap: begin
               if (period_end) begin
                  rem_q <= rem_q - 32'd1;
                  if (rem_q == 32'd1) begin
                     state_q <= StIdle;
                  end else if (en_i) begin
                     state_q <= StPulse;
                     step_q  <= 1'b1;
                     cnt_q   <= '0;
                     per_q   <= eff_period;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign step_o      = step_q;
   assign dir_o       = dir_q;
   assign busy_o      = (state_q != StIdle);
   assign remaining_o = rem_q;
   assign done_set_o  = period_end && (rem_q == 32'd1);

endmodule

// File: rtl/step_dir_axil.sv
// AXI4-Lite register front end for one step/direction axis (CTRL, PERIOD, STEPS, STATUS).
// Define STEP_DIR_IRQ_EN to add irq_o and the CTRL interrupt-enable bit.
module step_dir_axil
   import step_dir_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned PULSE_W            = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            step_o,
   output logic                            dir_o
`ifdef STEP_DIR_IRQ_EN
   ,
   output logic                            irq_o
`endif
);

   logic        awready_q, bvalid_q, arready_q, rvalid_q;
   resp_t       bresp_q;
   logic [31:0] rdata_q;
   logic        en_q, dir_q, done_q;
   logic [31:0] period_q;
`ifdef STEP_DIR_IRQ_EN
   logic        ie_q;
`endif

   logic        busy, done_set;
   logic [31:0] remaining;
   logic        wr_fire, rd_fire, wr_steps, steps_err, steps_load;
   logic [1:0]  wr_addr, rd_addr;
   logic [31:0] ctrl_rd, status_rd, ctrl_wr, rd_data;
   logic        unused_axi;

   assign unused_axi = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   assign wr_addr    = S_AXI_AWADDR[3:2];
   assign rd_addr    = S_AXI_ARADDR[3:2];
   assign wr_fire    = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_fire    = arready_q && S_AXI_ARVALID;
   assign wr_steps   = wr_fire && (wr_addr == REG_STEPS);
   assign steps_err  = wr_steps && busy;
   assign steps_load = wr_steps && !busy;

   always_comb begin
      ctrl_rd           = '0;
      ctrl_rd[CTRL_EN]  = en_q;
      ctrl_rd[CTRL_DIR] = dir_q;
`ifdef STEP_DIR_IRQ_EN
      ctrl_rd[CTRL_IE]  = ie_q;
`else
      ctrl_rd[CTRL_IE]  = 1'b0;
`endif
      status_rd            = '0;
      status_rd[STAT_BUSY] = busy;
      status_rd[STAT_DONE] = done_q;
   end

   assign ctrl_wr = apply_strb(ctrl_rd, S_AXI_WDATA, S_AXI_WSTRB);

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         REG_CTRL:   rd_data = ctrl_rd;
         REG_PERIOD: rd_data = period_q;
         REG_STEPS:  rd_data = remaining;
         REG_STATUS: rd_data = status_rd;
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         en_q      <= 1'b0;
         dir_q     <= 1'b0;
         done_q    <= 1'b0;
         period_q  <= '0;
`ifdef STEP_DIR_IRQ_EN
         ie_q      <= 1'b0;
`endif
      end else begin
         // AW and W are taken together; the !awready_q term keeps the ready a one-cycle pulse.
         awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
         if (wr_fire) begin
            bvalid_q <= 1'b1;
            bresp_q  <= steps_err ? SLVERR : OKAY;
         end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end

         if (wr_fire && wr_addr == REG_CTRL) begin
            en_q  <= ctrl_wr[CTRL_EN];
            dir_q <= ctrl_wr[CTRL_DIR];
`ifdef STEP_DIR_IRQ_EN
            ie_q  <= ctrl_wr[CTRL_IE];
`endif
         end
         if (wr_fire && wr_addr == REG_PERIOD) begin
            period_q <= apply_strb(period_q, S_AXI_WDATA, S_AXI_WSTRB);
         end

         // A completion in the same cycle as a write-1-to-clear keeps DONE set.
         if (done_set) begin
            done_q <= 1'b1;
         end else if (wr_fire && wr_addr == REG_STATUS && S_AXI_WSTRB[0]
                      && S_AXI_WDATA[STAT_DONE]) begin
            done_q <= 1'b0;
         end

         arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
         if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   step_dir_gen #(
      .PULSE_W (PULSE_W)
   ) u_gen (
      .clk_i       (S_AXI_ACLK),
      .rst_ni      (S_AXI_ARESETN),
      .en_i        (en_q),
      .dir_i       (dir_q),
      .period_i    (period_q),
      .load_i      (steps_load),
      .count_i     (apply_strb(remaining, S_AXI_WDATA, S_AXI_WSTRB)),
      .step_o      (step_o),
      .dir_o       (dir_o),
      .busy_o      (busy),
      .remaining_o (remaining),
      .done_set_o  (done_set)
   );

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = OKAY;
`ifdef STEP_DIR_IRQ_EN
   assign irq_o = done_q && ie_q;
`endif

endmodule

// File: tb/tb_step_dir_axil.sv
// Directed bench for step_dir_axil: register access, pulse timing, SLVERR, pause,
// back-pressure and asynchronous reset, with hand-computed expectations.
module tb_step_dir_axil;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        step, dir;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int wr_cyc = 0;

   int   rise [16];
   int   width[16];
   int   nrise = 0;
   int   nfall = 0;
   logic step_prev = 1'b0;

   always #5 clk = ~clk;

   step_dir_axil #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .PULSE_W            (4)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .step_o        (step),
      .dir_o         (dir)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Step edge monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (step && !step_prev && nrise < 16) begin
         rise[nrise] <= cyc;
         nrise       <= nrise + 1;
      end
      if (!step && step_prev && nfall < 16 && nrise > 0) begin
         width[nfall] <= cyc - rise[nrise-1];
         nfall        <= nfall + 1;
      end
      step_prev <= step;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit ok;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      resp = 2'b11;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (awready) ok = 1;
      end
      if (!ok) begin
         check("aw_timeout", 32'd0, 32'd1);
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      wr_cyc = cyc;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bvalid) begin
            resp = bresp;
            ok = 1;
         end
      end
      if (!ok) check("b_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit ok;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      data = 32'hDEAD_BEEF; resp = 2'b11;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (arready) ok = 1;
      end
      if (!ok) begin
         check("ar_timeout", 32'd0, 32'd1);
         arvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (rvalid) begin
            data = rdata; resp = rresp;
            ok = 1;
         end
      end
      if (!ok) check("r_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      int          rb, fb, n_aw, n_bv, n_ar, n_rv, n_rd;

      rst_n = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
      wdata = '0; wstrb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_step", 32'(step), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset values
      for (int a = 0; a < 4; a++) begin
         axi_read(4'(a * 4), rd, resp);
         check($sformatf("rst_reg%0d", a), rd, 32'd0);
         check($sformatf("rst_rresp%0d", a), 32'(resp), 32'd0);
      end

      // Three steps, period 10, dir 1
      axi_write(4'h4, 32'd10, 4'hF, resp);
      axi_write(4'h8, 32'd3, 4'hF, resp);
      check("steps_okay", 32'(resp), 32'd0);
      rb = nrise; fb = nfall;
      axi_write(4'h0, 32'h3, 4'hF, resp);
      repeat (45) @(posedge clk);
      #1;
      check("mv1_nrise", 32'(nrise - rb), 32'd3);
      check("mv1_latency", 32'(rise[rb]), 32'(wr_cyc + 1));
      check("mv1_gap0", 32'(rise[rb+1] - rise[rb]), 32'd10);
      check("mv1_gap1", 32'(rise[rb+2] - rise[rb+1]), 32'd10);
      check("mv1_w0", 32'(width[fb]), 32'd4);
      check("mv1_w1", 32'(width[fb+1]), 32'd4);
      check("mv1_w2", 32'(width[fb+2]), 32'd4);
      check("mv1_dir", 32'(dir), 32'd1);
      axi_read(4'hC, rd, resp);
      check("mv1_status", rd, 32'h2);
      axi_read(4'h8, rd, resp);
      check("mv1_steps", rd, 32'd0);
      axi_write(4'hC, 32'h2, 4'hF, resp);
      axi_read(4'hC, rd, resp);
      check("done_clr", rd, 32'h0);

      // SLVERR on STEPS while busy, then pause via EN=0
      axi_write(4'h0, 32'h0, 4'hF, resp);
      axi_write(4'h4, 32'd200, 4'hF, resp);
      axi_write(4'h8, 32'd6, 4'hF, resp);
      rb = nrise;
      axi_write(4'h0, 32'h1, 4'hF, resp);
      axi_write(4'h8, 32'd5, 4'hF, resp);
      check("busy_slverr", 32'(resp), 32'h2);
      axi_read(4'h8, rd, resp);
      check("busy_steps", rd, 32'd6);
      axi_read(4'hC, rd, resp);
      check("busy_status", rd, 32'h1);
      axi_write(4'h0, 32'h0, 4'hF, resp);
      repeat (250) @(posedge clk);
      #1;
      axi_read(4'hC, rd, resp);
      check("pause_status", rd, 32'h0);
      axi_read(4'h8, rd, resp);
      check("pause_steps", rd, 32'd5);
      check("pause_nrise", 32'(nrise - rb), 32'd1);
      check("pause_dir", 32'(dir), 32'd0);

      // Byte strobes
      axi_write(4'h4, 32'hAABB_CCDD, 4'hF, resp);
      axi_write(4'h4, 32'h0000_1100, 4'h2, resp);
      axi_read(4'h4, rd, resp);
      check("strb_period", rd, 32'hAABB_11DD);
      axi_write(4'h0, 32'hFFFF_FFFF, 4'h0, resp);
      axi_read(4'h0, rd, resp);
      check("strb_ctrl0", rd, 32'h0);
      axi_write(4'h0, 32'hFFFF_FFFE, 4'h1, resp);
      axi_read(4'h0, rd, resp);
      check("strb_ctrl1", rd, 32'h2);
      axi_write(4'h0, 32'h0, 4'hF, resp);

      // Short period clamps to PULSE_W+1
      axi_write(4'h4, 32'd1, 4'hF, resp);
      axi_write(4'h8, 32'd2, 4'hF, resp);
      check("min_steps_okay", 32'(resp), 32'd0);
      rb = nrise;
      axi_write(4'h0, 32'h1, 4'hF, resp);
      repeat (30) @(posedge clk);
      #1;
      check("min_nrise", 32'(nrise - rb), 32'd2);
      check("min_gap", 32'(rise[rb+1] - rise[rb]), 32'd5);
      axi_read(4'hC, rd, resp);
      check("min_status", rd, 32'h2);
      axi_write(4'hC, 32'h2, 4'hF, resp);

      // Back-pressure on B: a second request must not be accepted
      bready = 1'b0;
      awaddr = 4'h4; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      n_aw = 0;
      for (int i = 0; i < 20 && n_aw == 0; i++) begin
         @(negedge clk);
         if (awready) n_aw = 1;
      end
      check("hold_aw_seen", 32'(n_aw), 32'd1);
      @(posedge clk); #1;
      n_aw = 0; n_bv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (awready) n_aw++;
         if (!bvalid || bresp != 2'b00) n_bv++;
      end
      check("hold_no_aw", 32'(n_aw), 32'd0);
      check("hold_bvalid", 32'(n_bv), 32'd0);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_b_drop", 32'(bvalid), 32'd0);

      // Back-pressure on R
      rready = 1'b0;
      araddr = 4'h4; arvalid = 1'b1;
      n_ar = 0;
      for (int i = 0; i < 20 && n_ar == 0; i++) begin
         @(negedge clk);
         if (arready) n_ar = 1;
      end
      check("hold_ar_seen", 32'(n_ar), 32'd1);
      @(posedge clk); #1;
      n_ar = 0; n_rv = 0; n_rd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (arready) n_ar++;
         if (!rvalid) n_rv++;
         if (rdata != 32'h1234) n_rd++;
      end
      check("hold_no_ar", 32'(n_ar), 32'd0);
      check("hold_rvalid", 32'(n_rv), 32'd0);
      check("hold_rdata", 32'(n_rd), 32'd0);
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b1;
      @(posedge clk); #1;

      // AW without W
      awaddr = 4'h4; awvalid = 1'b1; wvalid = 1'b0;
      n_aw = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (awready || wready) n_aw++;
      end
      check("aw_only", 32'(n_aw), 32'd0);
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset mid-pulse with a pending BVALID
      axi_write(4'h0, 32'h0, 4'hF, resp);
      axi_write(4'h4, 32'd20, 4'hF, resp);
      axi_write(4'h8, 32'd3, 4'hF, resp);
      bready = 1'b0;
      awaddr = 4'h0; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      n_aw = 0;
      for (int i = 0; i < 20 && n_aw == 0; i++) begin
         @(negedge clk);
         if (awready) n_aw = 1;
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      check("pre_rst_step", 32'(step), 32'd1);
      check("pre_rst_bvalid", 32'(bvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_step", 32'(step), 32'd0);
      check("arst_bvalid", 32'(bvalid), 32'd0);
      check("arst_dir", 32'(dir), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bready = 1'b1;
      @(posedge clk); #1;
      for (int a = 0; a < 4; a++) begin
         axi_read(4'(a * 4), rd, resp);
         check($sformatf("arst_reg%0d", a), rd, 32'd0);
      end
      check("arst_step_after", 32'(step), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
